// File: rtl/block_move_ctrl.sv
// Button-driven block motion controller: synchronise and debounce four buttons, pick a
// direction by fixed priority, and commit single/auto-repeat steps at vertical blank.
module block_move_ctrl #(
  parameter int DEBOUNCE_MAX = 500000,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6,
  parameter int H_CELLS      = 20,
  parameter int V_CELLS      = 15,
  parameter int V_ACTIVE     = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic [4:0]  h_pos,
  output logic [3:0]  v_pos,
  output logic        move_pulse,
  output logic [1:0]  held_dir,
  output logic        active
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MAX - 1);
  localparam logic [5:0]      RD      = 6'(REPEAT_DELAY);
  localparam logic [5:0]      RR      = 6'(REPEAT_RATE);
  localparam logic [4:0]      H_LAST  = 5'(H_CELLS - 1);
  localparam logic [3:0]      V_LAST  = 4'(V_CELLS - 1);
  localparam logic [10:0]     V_TICK  = 11'(V_ACTIVE);

  localparam logic [1:0] DIR_U = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_R = 2'd3;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Bit index matches the direction encoding: 0=up, 1=down, 2=left, 3=right.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_r, btn_l, btn_d, btn_u};

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];

  state_t     state_q, state_d;
  logic [1:0] held_dir_q, held_dir_d;
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic [5:0] frame_cnt_inc;
  logic       pending_q, pending_d;
  logic       pend_set;
  logic [4:0] h_pos_q, h_pos_d;
  logic [3:0] v_pos_q, v_pos_d;
  logic       move_pulse_q, move_pulse_d;

  logic       frame_tick;
  logic       any_btn;
  logic       held_btn;
  logic [1:0] win_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Counter runs only while the synchronised level disagrees; the flip lands on the
  // DEBOUNCE_MAX-th consecutive disagreeing cycle.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign frame_tick = (vcount == V_TICK) && (hcount == 11'd0);

  always_comb begin
    any_btn = |deb_q;
    if (deb_q[0])      win_dir = DIR_U;
    else if (deb_q[1]) win_dir = DIR_D;
    else if (deb_q[2]) win_dir = DIR_L;
    else               win_dir = DIR_R;
    held_btn = deb_q[held_dir_q];
  end

  assign frame_cnt_inc = frame_cnt_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    held_dir_d  = held_dir_q;
    frame_cnt_d = frame_cnt_q;
    pend_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_btn) begin
          held_dir_d  = win_dir;
          pend_set    = 1'b1;
          frame_cnt_d = '0;
          state_d     = DELAY;
        end
      end
      DELAY: begin
        if (!held_btn) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (frame_cnt_inc == RD) begin
            pend_set    = 1'b1;
            frame_cnt_d = '0;
            state_d     = REPEAT;
          end else begin
            frame_cnt_d = frame_cnt_inc;
          end
        end
      end
      REPEAT: begin
        if (!held_btn) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (frame_cnt_inc == RR) begin
            pend_set    = 1'b1;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A tick consumes the old pending value; a set arriving in the same cycle survives.
  assign pending_d = pend_set | (pending_q & ~frame_tick);

  always_comb begin
    h_pos_d      = h_pos_q;
    v_pos_d      = v_pos_q;
    move_pulse_d = 1'b0;
    if (frame_tick && pending_q) begin
      case (held_dir_q)
        DIR_U: if (v_pos_q != 4'd0) begin
          v_pos_d      = v_pos_q - 4'd1;
          move_pulse_d = 1'b1;
        end
        DIR_D: if (v_pos_q != V_LAST) begin
          v_pos_d      = v_pos_q + 4'd1;
          move_pulse_d = 1'b1;
        end
        DIR_L: if (h_pos_q != 5'd0) begin
          h_pos_d      = h_pos_q - 5'd1;
          move_pulse_d = 1'b1;
        end
        default: if (h_pos_q != H_LAST) begin
          h_pos_d      = h_pos_q + 5'd1;
          move_pulse_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      held_dir_q   <= DIR_U;
      frame_cnt_q  <= '0;
      pending_q    <= 1'b0;
      h_pos_q      <= '0;
      v_pos_q      <= '0;
      move_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_dir_q   <= held_dir_d;
      frame_cnt_q  <= frame_cnt_d;
      pending_q    <= pending_d;
      h_pos_q      <= h_pos_d;
      v_pos_q      <= v_pos_d;
      move_pulse_q <= move_pulse_d;
    end
  end

  assign h_pos      = h_pos_q;
  assign v_pos      = v_pos_q;
  assign move_pulse = move_pulse_q;
  assign held_dir   = held_dir_q;
  assign active     = (state_q != IDLE);

endmodule

// File: tb/tb_block_move_ctrl.sv
// Directed bench for block_move_ctrl using a short 8x4 frame (tick every 32 cycles).
module tb_block_move_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic [4:0]  h_pos;
  logic [3:0]  v_pos;
  logic        move_pulse;
  logic [1:0]  held_dir;
  logic        active;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_num = 0;
  int pulse_cnt = 0;
  int pulse_tick [64];

  block_move_ctrl #(
    .DEBOUNCE_MAX(4), .REPEAT_DELAY(3), .REPEAT_RATE(2),
    .H_CELLS(20), .V_CELLS(15), .V_ACTIVE(2)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .hcount(hcount), .vcount(vcount),
    .h_pos(h_pos), .v_pos(v_pos), .move_pulse(move_pulse),
    .held_dir(held_dir), .active(active)
  );

  always #5 clk = ~clk;

  // Short frame: 8 columns x 4 lines, blanking starts on line 2.
  always @(posedge clk) begin
    if (hcount == 11'd7) begin
      hcount <= '0;
      vcount <= (vcount == 11'd3) ? 11'd0 : vcount + 11'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  // Pulses are tagged with the number of the tick that caused them.
  always @(negedge clk) begin
    if (move_pulse) begin
      if (pulse_cnt < 64) pulse_tick[pulse_cnt] = tick_num;
      pulse_cnt++;
    end
    if (vcount == 11'd2 && hcount == 11'd0) tick_num++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(3);
    n_cmp++; if (h_pos !== 5'd0) begin n_bad++; $display("FAIL reset_h_pos: got %0d want 0", h_pos); end
    n_cmp++; if (v_pos !== 4'd0) begin n_bad++; $display("FAIL reset_v_pos: got %0d want 0", v_pos); end
    n_cmp++; if (move_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", move_pulse); end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", active); end
    n_cmp++; if (held_dir !== 2'd0) begin n_bad++; $display("FAIL reset_held_dir: got %0d want 0", held_dir); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_single_press;
    int p0;
    do_reset();
    p0 = pulse_cnt;
    btn_r = 1'b1;
    cyc(10);
    btn_r = 1'b0;
    cyc(70);
    n_cmp++; if (h_pos !== 5'd1) begin n_bad++; $display("FAIL single_h_pos: got %0d want 1", h_pos); end
    n_cmp++; if (v_pos !== 4'd0) begin n_bad++; $display("FAIL single_v_pos: got %0d want 0", v_pos); end
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", pulse_cnt - p0); end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL single_active_after: got %b want 0", active); end
  endtask

  task automatic test_bounce;
    int  p0;
    logic seen;
    p0 = pulse_cnt;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      btn_d = (i % 3) != 2;
      cyc(1);
      if (active) seen = 1'b1;
    end
    btn_d = 1'b0;
    cyc(70);
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL bounce_active_seen: got %b want 0", seen); end
    n_cmp++; if (v_pos !== 4'd0) begin n_bad++; $display("FAIL bounce_v_pos: got %0d want 0", v_pos); end
    n_cmp++; if (h_pos !== 5'd1) begin n_bad++; $display("FAIL bounce_h_pos: got %0d want 1", h_pos); end
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL bounce_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_auto_repeat;
    int p0;
    int first;
    int exp_rel [5];
    exp_rel = '{1, 4, 6, 8, 10};
    do_reset();
    p0 = pulse_cnt;
    btn_r = 1'b1;
    for (int i = 0; i < 200 && pulse_cnt == p0; i++) cyc(1);
    first = (pulse_cnt > p0) ? pulse_tick[p0] : tick_num;
    for (int i = 0; i < 400 && tick_num < first + 9; i++) cyc(1);
    cyc(3);
    btn_r = 1'b0;
    cyc(70);
    n_cmp++; if (pulse_cnt - p0 !== 5) begin n_bad++; $display("FAIL repeat_pulses: got %0d want 5", pulse_cnt - p0); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (pulse_tick[p0 + k] - first + 1 !== exp_rel[k]) begin
        n_bad++;
        $display("FAIL repeat_step%0d_tick: got %0d want %0d", k, pulse_tick[p0 + k] - first + 1, exp_rel[k]);
      end
    end
    n_cmp++; if (h_pos !== 5'd5) begin n_bad++; $display("FAIL repeat_h_pos: got %0d want 5", h_pos); end
  endtask

  task automatic test_clamping;
    int p0;
    do_reset();
    p0 = pulse_cnt;
    btn_u = 1'b1; cyc(10); btn_u = 1'b0; cyc(70);
    btn_l = 1'b1; cyc(10); btn_l = 1'b0; cyc(70);
    n_cmp++; if (h_pos !== 5'd0 || v_pos !== 4'd0) begin n_bad++; $display("FAIL clamp_origin: got (%0d,%0d) want (0,0)", h_pos, v_pos); end
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL clamp_origin_pulses: got %0d want 0", pulse_cnt - p0); end
    btn_d = 1'b1;
    cyc(34 * 32);
    btn_d = 1'b0;
    cyc(70);
    n_cmp++; if (v_pos !== 4'd14) begin n_bad++; $display("FAIL clamp_v_pos: got %0d want 14", v_pos); end
    n_cmp++; if (pulse_cnt - p0 !== 14) begin n_bad++; $display("FAIL clamp_pulses: got %0d want 14", pulse_cnt - p0); end
  endtask

  task automatic test_priority;
    btn_l = 1'b1; btn_u = 1'b1;
    cyc(10);
    n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL prio_active: got %b want 1", active); end
    n_cmp++; if (held_dir !== 2'd0) begin n_bad++; $display("FAIL prio_held_dir: got %0d want 0", held_dir); end
    btn_l = 1'b0; btn_u = 1'b0;
    cyc(70);
    n_cmp++; if (v_pos !== 4'd13 || h_pos !== 5'd0) begin n_bad++; $display("FAIL prio_pos: got (%0d,%0d) want (0,13)", h_pos, v_pos); end
    btn_u = 1'b1;
    cyc(10);
    btn_d = 1'b1;
    cyc(54);
    n_cmp++; if (v_pos !== 4'd12) begin n_bad++; $display("FAIL prio_hold_v_pos: got %0d want 12", v_pos); end
    n_cmp++; if (held_dir !== 2'd0) begin n_bad++; $display("FAIL prio_hold_dir: got %0d want 0", held_dir); end
    btn_u = 1'b0;
    cyc(15);
    n_cmp++; if (held_dir !== 2'd1 || active !== 1'b1) begin n_bad++; $display("FAIL prio_switch: got dir %0d active %b want dir 1 active 1", held_dir, active); end
    btn_d = 1'b0;
    cyc(70);
    n_cmp++; if (v_pos !== 4'd13) begin n_bad++; $display("FAIL prio_final_v_pos: got %0d want 13", v_pos); end
  endtask

  task automatic test_reset_mid_repeat;
    do_reset();
    btn_r = 1'b1;
    for (int i = 0; i < 600 && h_pos != 5'd5; i++) cyc(1);
    btn_r = 1'b0;
    cyc(70);
    btn_d = 1'b1;
    for (int i = 0; i < 600 && v_pos != 4'd5; i++) cyc(1);
    n_cmp++; if (h_pos !== 5'd5 || v_pos !== 4'd5 || active !== 1'b1) begin n_bad++; $display("FAIL midrep_setup: got (%0d,%0d) active %b want (5,5) active 1", h_pos, v_pos, active); end
    reset = 1'b1;
    #1;
    n_cmp++; if (h_pos !== 5'd0 || v_pos !== 4'd0) begin n_bad++; $display("FAIL midrep_async_pos: got (%0d,%0d) want (0,0)", h_pos, v_pos); end
    n_cmp++; if (active !== 1'b0 || move_pulse !== 1'b0) begin n_bad++; $display("FAIL midrep_async_ctrl: got active %b pulse %b want 0 0", active, move_pulse); end
    cyc(1);
    reset = 1'b0;
    cyc(70);
    n_cmp++; if (v_pos !== 4'd1 || h_pos !== 5'd0) begin n_bad++; $display("FAIL midrep_restart_pos: got (%0d,%0d) want (0,1)", h_pos, v_pos); end
    n_cmp++; if (active !== 1'b1 || held_dir !== 2'd1) begin n_bad++; $display("FAIL midrep_restart_state: got active %b dir %0d want 1 1", active, held_dir); end
    btn_d = 1'b0;
    cyc(70);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_clamping();
    test_priority();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_move_ctrl.md
# block_move_ctrl

Frame-synchronous motion controller for the movable block on the 20×15 grid of 32-pixel cells. It conditions the four raw push-buttons with synchronisers and debounce. It arbitrates simultaneous presses by fixed priority and generates single-step and auto-repeat move requests. Position updates are committed only at the start of vertical blanking, so the block never tears mid-frame. It sits between the board buttons and the block renderer, and drives the renderer's cell coordinates.

## Interface
Parameters:
- DEBOUNCE_MAX, 500000: clk cycles a synchronised button must hold a new level before the debounced state follows it (20 ms at 25 MHz).
- REPEAT_DELAY, 30: frames a direction is held before auto-repeat starts (1–63).
- REPEAT_RATE, 6: frames between auto-repeat steps (1–63).
- H_CELLS, 20: horizontal cell count. h_pos range is 0..H_CELLS-1.
- V_CELLS, 15: vertical cell count. v_pos range is 0..V_CELLS-1.
- V_ACTIVE, 480: first vcount value of vertical blanking.

Ports:
- clk, in, 1: pixel clock. hcount advances once per clk.
- reset, in, 1: asynchronous, active-high.
- btn_u, btn_d, btn_l, btn_r, in, 1 each: raw asynchronous buttons, active-high.
- hcount, in, 11: current pixel column from the VGA timing generator.
- vcount, in, 11: current line from the VGA timing generator.
- h_pos, out, 5: committed block column.
- v_pos, out, 4: committed block row.
- move_pulse, out, 1: one-cycle pulse on the cycle after a commit that changed the position.
- held_dir, out, 2: latched direction (0=up, 1=down, 2=left, 3=right). Valid only while active is 1.
- active, out, 1: high while the FSM is in DELAY or REPEAT.

## Operation
- Synchronisers: 2-flop synchroniser per button.
- Debounce: one counter per button, width clog2(DEBOUNCE_MAX+1).
  - Counter clears whenever the synchronised level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_MAX, the debounced level flips and the counter clears.
- Frame tick: one-cycle strobe asserted when vcount==V_ACTIVE and hcount==0.
- Arbitration: among debounced-high buttons, priority is up > down > left > right.
- FSM states:
  - IDLE: if any debounced button is high, latch the winning direction into held_dir, set pending, clear frame_cnt, and go to DELAY.
  - DELAY: if the latched button is debounced-low, go to IDLE. Otherwise, on each frame tick increment frame_cnt. When frame_cnt reaches REPEAT_DELAY, set pending, clear frame_cnt, and go to REPEAT.
  - REPEAT: if the latched button is debounced-low, go to IDLE. Otherwise, on each frame tick increment frame_cnt. When frame_cnt reaches REPEAT_RATE, set pending and clear frame_cnt.
- Priority is evaluated only in IDLE. A higher-priority press while another direction is held is ignored until the latched button releases.
- Commit:
  - On a frame tick with pending set, apply one step in held_dir's direction, with clamping and no wrap:
    - up: only if v_pos≠0.
    - down: only if v_pos≠V_CELLS-1.
    - left: only if h_pos≠0.
    - right: only if h_pos≠H_CELLS-1.
  - Pending clears on every frame tick.
  - move_pulse fires only if the position actually changed.
- Coalescing: multiple pending sets between two ticks produce a single step.
- Simultaneous events: if pending is set and the frame tick occur in the same cycle, the commit uses the old pending value and the new set survives to the next tick.
- Release: if the latched button releases while pending is set, the pending step still commits at the next tick.
- Reset values: h_pos=0, v_pos=0, move_pulse=0, held_dir=0, active=0, pending=0, state=IDLE, debounced levels=0, all counters=0, synchronisers=0.

## Timing
- Synchronised level of a raw edge: cycle 2.
- Debounced flip: DEBOUNCE_MAX cycles after the synchronised level stabilises.
- FSM latches direction and sets pending one cycle after the debounced flip.
- h_pos/v_pos change in the cycle after the frame tick. move_pulse is high that same cycle only.
- First repeat step commits at the tick that is REPEAT_DELAY ticks after the initial commit tick. Subsequent steps follow every REPEAT_RATE ticks.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A button still held after reset deasserts is treated as a fresh press once debounced.
- The block has no handshake with the renderer. Outputs are stable throughout the active video region.

## Test plan
- **Single press:** use DEBOUNCE_MAX=4 and V_ACTIVE=2 with a short frame model. Hold btn_r for 10 cycles. Required: h_pos 0→1 in the cycle after the next tick, one move_pulse, v_pos stays 0.
- **Bounce rejection:** toggle btn_d with a period of 3 cycles for 40 cycles, then release. Required: no debounced change, v_pos stays 0, no move_pulse.
- **Auto-repeat:** set REPEAT_DELAY=3 and REPEAT_RATE=2, then hold btn_r for 10 frames. Required: h_pos steps at ticks 1, 4, 6, 8, 10 (relative to the first commit tick), ending at 5.
- **Clamping:** from reset, press btn_u, then btn_l. Required: position stays (0,0) and no move_pulse. Hold btn_d past 14 steps. Required: v_pos saturates at 14.
- **Priority:** press btn_l and btn_u in the same cycle. Required: held_dir=0, v_pos moves. Press btn_u first, then btn_d, while holding btn_u. Required: btn_d is ignored until btn_u releases.
- **Reset mid-repeat:** with the position at (5,5) in REPEAT, pulse reset. Required: outputs return to 0 the same cycle and active=0. Continued hold restarts at a single step after debounce.
